// File: rtl/aes_pkg.sv
// Shared AES datapath definitions: widths, byte addressing and the iterative-engine FSM states.
package aes_pkg;

  localparam int unsigned AES_STATE_W = 128;
  localparam int unsigned AES_BYTE_W  = 8;
  localparam int unsigned AES_IDX_W   = $clog2(AES_STATE_W);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } aes_fsm_e;

  // Byte k of a state occupies bits [8k:8k+7] of an ascending [0:127] vector.
  function automatic int unsigned byte_lsb(input int unsigned k);
    return k * AES_BYTE_W;
  endfunction

endpackage

// File: rtl/inv_s_box.sv
// FIPS-197 inverse S-box, purely combinational lookup.
module inv_s_box
  import aes_pkg::*;
(
  input  logic [AES_BYTE_W-1:0] iByte,
  output logic [AES_BYTE_W-1:0] oByte
);

  always_comb begin
    oByte = 8'h00;
    case (iByte)
      8'h00: oByte = 8'h52; 8'h01: oByte = 8'h09; 8'h02: oByte = 8'h6a; 8'h03: oByte = 8'hd5;
      8'h04: oByte = 8'h30; 8'h05: oByte = 8'h36; 8'h06: oByte = 8'ha5; 8'h07: oByte = 8'h38;
      8'h08: oByte = 8'hbf; 8'h09: oByte = 8'h40; 8'h0a: oByte = 8'ha3; 8'h0b: oByte = 8'h9e;
      8'h0c: oByte = 8'h81; 8'h0d: oByte = 8'hf3; 8'h0e: oByte = 8'hd7; 8'h0f: oByte = 8'hfb;
      8'h10: oByte = 8'h7c; 8'h11: oByte = 8'he3; 8'h12: oByte = 8'h39; 8'h13: oByte = 8'h82;
      8'h14: oByte = 8'h9b; 8'h15: oByte = 8'h2f; 8'h16: oByte = 8'hff; 8'h17: oByte = 8'h87;
      8'h18: oByte = 8'h34; 8'h19: oByte = 8'h8e; 8'h1a: oByte = 8'h43; 8'h1b: oByte = 8'h44;
      8'h1c: oByte = 8'hc4; 8'h1d: oByte = 8'hde; 8'h1e: oByte = 8'he9; 8'h1f: oByte = 8'hcb;
      8'h20: oByte = 8'h54; 8'h21: oByte = 8'h7b; 8'h22: oByte = 8'h94; 8'h23: oByte = 8'h32;
      8'h24: oByte = 8'ha6; 8'h25: oByte = 8'hc2; 8'h26: oByte = 8'h23; 8'h27: oByte = 8'h3d;
      8'h28: oByte = 8'hee; 8'h29: oByte = 8'h4c; 8'h2a: oByte = 8'h95; 8'h2b: oByte = 8'h0b;
      8'h2c: oByte = 8'h42; 8'h2d: oByte = 8'hfa; 8'h2e: oByte = 8'hc3; 8'h2f: oByte = 8'h4e;
      8'h30: oByte = 8'h08; 8'h31: oByte = 8'h2e; 8'h32: oByte = 8'ha1; 8'h33: oByte = 8'h66;
      8'h34: oByte = 8'h28; 8'h35: oByte = 8'hd9; 8'h36: oByte = 8'h24; 8'h37: oByte = 8'hb2;
      8'h38: oByte = 8'h76; 8'h39: oByte = 8'h5b; 8'h3a: oByte = 8'ha2; 8'h3b: oByte = 8'h49;
      8'h3c: oByte = 8'h6d; 8'h3d: oByte = 8'h8b; 8'h3e: oByte = 8'hd1; 8'h3f: oByte = 8'h25;
      8'h40: oByte = 8'h72; 8'h41: oByte = 8'hf8; 8'h42: oByte = 8'hf6; 8'h43: oByte = 8'h64;
      8'h44: oByte = 8'h86; 8'h45: oByte = 8'h68; 8'h46: oByte = 8'h98; 8'h47: oByte = 8'h16;
      8'h48: oByte = 8'hd4; 8'h49: oByte = 8'ha4; 8'h4a: oByte = 8'h5c; 8'h4b: oByte = 8'hcc;
      8'h4c: oByte = 8'h5d; 8'h4d: oByte = 8'h65; 8'h4e: oByte = 8'hb6; 8'h4f: oByte = 8'h92;
      8'h50: oByte = 8'h6c; 8'h51: oByte = 8'h70; 8'h52: oByte = 8'h48; 8'h53: oByte = 8'h50;
      8'h54: oByte = 8'hfd; 8'h55: oByte = 8'hed; 8'h56: oByte = 8'hb9; 8'h57: oByte = 8'hda;
      8'h58: oByte = 8'h5e; 8'h59: oByte = 8'h15; 8'h5a: oByte = 8'h46; 8'h5b: oByte = 8'h57;
      8'h5c: oByte = 8'ha7; 8'h5d: oByte = 8'h8d; 8'h5e: oByte = 8'h9d; 8'h5f: oByte = 8'h84;
      8'h60: oByte = 8'h90; 8'h61: oByte = 8'hd8; 8'h62: oByte = 8'hab; 8'h63: oByte = 8'h00;
      8'h64: oByte = 8'h8c; 8'h65: oByte = 8'hbc; 8'h66: oByte = 8'hd3; 8'h67: oByte = 8'h0a;
      8'h68: oByte = 8'hf7; 8'h69: oByte = 8'he4; 8'h6a: oByte = 8'h58; 8'h6b: oByte = 8'h05;
      8'h6c: oByte = 8'hb8; 8'h6d: oByte = 8'hb3; 8'h6e: oByte = 8'h45; 8'h6f: oByte = 8'h06;
      8'h70: oByte = 8'hd0; 8'h71: oByte = 8'h2c; 8'h72: oByte = 8'h1e; 8'h73: oByte = 8'h8f;
      8'h74: oByte = 8'hca; 8'h75: oByte = 8'h3f; 8'h76: oByte = 8'h0f; 8'h77: oByte = 8'h02;
      8'h78: oByte = 8'hc1; 8'h79: oByte = 8'haf; 8'h7a: oByte = 8'hbd; 8'h7b: oByte = 8'h03;
      8'h7c: oByte = 8'h01; 8'h7d: oByte = 8'h13; 8'h7e: oByte = 8'h8a; 8'h7f: oByte = 8'h6b;
      8'h80: oByte = 8'h3a; 8'h81: oByte = 8'h91; 8'h82: oByte = 8'h11; 8'h83: oByte = 8'h41;
      8'h84: oByte = 8'h4f; 8'h85: oByte = 8'h67; 8'h86: oByte = 8'hdc; 8'h87: oByte = 8'hea;
      8'h88: oByte = 8'h97; 8'h89: oByte = 8'hf2; 8'h8a: oByte = 8'hcf; 8'h8b: oByte = 8'hce;
      8'h8c: oByte = 8'hf0; 8'h8d: oByte = 8'hb4; 8'h8e: oByte = 8'he6; 8'h8f: oByte = 8'h73;
      8'h90: oByte = 8'h96; 8'h91: oByte = 8'hac; 8'h92: oByte = 8'h74; 8'h93: oByte = 8'h22;
      8'h94: oByte = 8'he7; 8'h95: oByte = 8'had; 8'h96: oByte = 8'h35; 8'h97: oByte = 8'h85;
      8'h98: oByte = 8'he2; 8'h99: oByte = 8'hf9; 8'h9a: oByte = 8'h37; 8'h9b: oByte = 8'he8;
      8'h9c: oByte = 8'h1c; 8'h9d: oByte = 8'h75; 8'h9e: oByte = 8'hdf; 8'h9f: oByte = 8'h6e;
      8'ha0: oByte = 8'h47; 8'ha1: oByte = 8'hf1; 8'ha2: oByte = 8'h1a; 8'ha3: oByte = 8'h71;
      8'ha4: oByte = 8'h1d; 8'ha5: oByte = 8'h29; 8'ha6: oByte = 8'hc5; 8'ha7: oByte = 8'h89;
      8'ha8: oByte = 8'h6f; 8'ha9: oByte = 8'hb7; 8'haa: oByte = 8'h62; 8'hab: oByte = 8'h0e;
      8'hac: oByte = 8'haa; 8'had: oByte = 8'h18; 8'hae: oByte = 8'hbe; 8'haf: oByte = 8'h1b;
      8'hb0: oByte = 8'hfc; 8'hb1: oByte = 8'h56; 8'hb2: oByte = 8'h3e; 8'hb3: oByte = 8'h4b;
      8'hb4: oByte = 8'hc6; 8'hb5: oByte = 8'hd2; 8'hb6: oByte = 8'h79; 8'hb7: oByte = 8'h20;
      8'hb8: oByte = 8'h9a; 8'hb9: oByte = 8'hdb; 8'hba: oByte = 8'hc0; 8'hbb: oByte = 8'hfe;
      8'hbc: oByte = 8'h78; 8'hbd: oByte = 8'hcd; 8'hbe: oByte = 8'h5a; 8'hbf: oByte = 8'hf4;
      8'hc0: oByte = 8'h1f; 8'hc1: oByte = 8'hdd; 8'hc2: oByte = 8'ha8; 8'hc3: oByte = 8'h33;
      8'hc4: oByte = 8'h88; 8'hc5: oByte = 8'h07; 8'hc6: oByte = 8'hc7; 8'hc7: oByte = 8'h31;
      8'hc8: oByte = 8'hb1; 8'hc9: oByte = 8'h12; 8'hca: oByte = 8'h10; 8'hcb: oByte = 8'h59;
      8'hcc: oByte = 8'h27; 8'hcd: oByte = 8'h80; 8'hce: oByte = 8'hec; 8'hcf: oByte = 8'h5f;
      8'hd0: oByte = 8'h60; 8'hd1: oByte = 8'h51; 8'hd2: oByte = 8'h7f; 8'hd3: oByte = 8'ha9;
      8'hd4: oByte = 8'h19; 8'hd5: oByte = 8'hb5; 8'hd6: oByte = 8'h4a; 8'hd7: oByte = 8'h0d;
      8'hd8: oByte = 8'h2d; 8'hd9: oByte = 8'he5; 8'hda: oByte = 8'h7a; 8'hdb: oByte = 8'h9f;
      8'hdc: oByte = 8'h93; 8'hdd: oByte = 8'hc9; 8'hde: oByte = 8'h9c; 8'hdf: oByte = 8'hef;
      8'he0: oByte = 8'ha0; 8'he1: oByte = 8'he0; 8'he2: oByte = 8'h3b; 8'he3: oByte = 8'h4d;
      8'he4: oByte = 8'hae; 8'he5: oByte = 8'h2a; 8'he6: oByte = 8'hf5; 8'he7: oByte = 8'hb0;
      8'he8: oByte = 8'hc8; 8'he9: oByte = 8'heb; 8'hea: oByte = 8'hbb; 8'heb: oByte = 8'h3c;
      8'hec: oByte = 8'h83; 8'hed: oByte = 8'h53; 8'hee: oByte = 8'h99; 8'hef: oByte = 8'h61;
      8'hf0: oByte = 8'h17; 8'hf1: oByte = 8'h2b; 8'hf2: oByte = 8'h04; 8'hf3: oByte = 8'h7e;
      8'hf4: oByte = 8'hba; 8'hf5: oByte = 8'h77; 8'hf6: oByte = 8'hd6; 8'hf7: oByte = 8'h26;
      8'hf8: oByte = 8'he1; 8'hf9: oByte = 8'h69; 8'hfa: oByte = 8'h14; 8'hfb: oByte = 8'h63;
      8'hfc: oByte = 8'h55; 8'hfd: oByte = 8'h21; 8'hfe: oByte = 8'h0c; 8'hff: oByte = 8'h7d;
      default: oByte = 8'h00;
    endcase
  end

endmodule

// File: rtl/inv_sub_byte_iter.sv
// Iterative InvSubBytes: substitutes LANES bytes of a 128-bit state per cycle between
// a capture handshake and a result handshake; the working register is the output register.
module inv_sub_byte_iter
  import aes_pkg::*;
#(
  parameter int unsigned LANES = 4
) (
  input  logic                   iClk,
  input  logic                   iRstn,
  input  logic                   iValid,
  output logic                   oReady,
  input  logic [0:AES_STATE_W-1] iState,
  output logic                   oValid,
  input  logic                   iReady,
  output logic [0:AES_STATE_W-1] oState,
  output logic                   oBusy
);

  localparam int unsigned N    = 16 / LANES;
  localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;

  aes_fsm_e               state_q, state_d;
  logic [0:AES_STATE_W-1] work_q, work_d;
  logic [CntW-1:0]        cnt_q, cnt_d;

  logic [AES_IDX_W-1:0]  lane_lsb [LANES];
  logic [AES_BYTE_W-1:0] sb_in    [LANES];
  logic [AES_BYTE_W-1:0] sb_out   [LANES];

  // Group select: lane l works on byte cnt*LANES + l of the working register.
  always_comb begin
    for (int unsigned l = 0; l < LANES; l++) begin
      lane_lsb[l] = AES_IDX_W'(byte_lsb(32'(cnt_q) * LANES + l));
      sb_in[l]    = work_q[lane_lsb[l] +: AES_BYTE_W];
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    inv_s_box u_inv_s_box (
      .iByte(sb_in[g]),
      .oByte(sb_out[g])
    );
  end

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (iValid) begin
          work_d  = iState;
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        for (int unsigned l = 0; l < LANES; l++) begin
          work_d[lane_lsb[l] +: AES_BYTE_W] = sb_out[l];
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntW'(N - 1)) begin
          state_d = StDone;
        end
      end
      StDone: begin
        if (iReady) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge iClk or negedge iRstn) begin
    if (!iRstn) begin
      state_q <= StIdle;
      work_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
    end
  end

  assign oReady = (state_q == StIdle);
  assign oBusy  = (state_q == StRun);
  assign oValid = (state_q == StDone);
  assign oState = work_q;

endmodule

// File: tb/tb_inv_sub_byte_iter.sv
// Self-checking bench for inv_sub_byte_iter: directed cases, a LANES sweep and a random stream
// scored against an inverse S-box derived from GF(2^8) arithmetic.
module tb_inv_sub_byte_iter;

  logic         clk;
  logic         rst_n;
  logic         iValid, iReady;
  logic [0:127] iState;
  logic         oReady, oValid, oBusy;
  logic [0:127] oState;

  logic         sw_valid, sw_ready;
  logic [0:127] sw_state;
  logic         sw_oready [4];
  logic         sw_ovalid [4];
  logic         sw_obusy  [4];
  logic [0:127] sw_ostate [4];

  int errors = 0;
  int checks = 0;
  logic [7:0] inv_tab [256];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  inv_sub_byte_iter #(.LANES(4)) u_dut (
    .iClk  (clk),
    .iRstn (rst_n),
    .iValid(iValid),
    .oReady(oReady),
    .iState(iState),
    .oValid(oValid),
    .iReady(iReady),
    .oState(oState),
    .oBusy (oBusy)
  );

  // Sweep instances with LANES = 1, 2, 8, 16.
  for (genvar g = 0; g < 4; g++) begin : g_sweep
    inv_sub_byte_iter #(.LANES((g < 2) ? (1 << g) : (1 << (g + 1)))) u_dut (
      .iClk  (clk),
      .iRstn (rst_n),
      .iValid(sw_valid),
      .oReady(sw_oready[g]),
      .iState(sw_state),
      .oValid(sw_ovalid[g]),
      .iReady(sw_ready),
      .oState(sw_ostate[g]),
      .oBusy (sw_obusy[g])
    );
  end

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    logic [7:0] r;
    r = v;
    for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  // InvSbox(y) = GF inverse of the inverse affine transform of y.
  function automatic logic [7:0] inv_sbox_math(input logic [7:0] y);
    logic [7:0] x;
    logic [7:0] inv;
    x   = rotl(y, 1) ^ rotl(y, 3) ^ rotl(y, 6) ^ 8'h05;
    inv = 8'h00;
    for (int c = 1; c < 256; c++) begin
      if (gmul(x, 8'(c)) == 8'h01) inv = 8'(c);
    end
    return inv;
  endfunction

  function automatic logic [0:127] ref_sub(input logic [0:127] s);
    logic [0:127] r;
    for (int k = 0; k < 16; k++) r[8*k +: 8] = inv_tab[s[8*k +: 8]];
    return r;
  endfunction

  function automatic logic [0:127] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check128(input string tag, input logic [0:127] obs, input logic [0:127] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One transaction on the main DUT; expects it idle on entry, leaves it idle on exit.
  task automatic run_one(input logic [0:127] s, output logic [0:127] res, output int lat);
    iState = s;
    iValid = 1'b1;
    iReady = 1'b0;
    tick();
    iValid = 1'b0;
    iState = rand128();
    lat = 0;
    while (!oValid && lat < 40) begin
      tick();
      lat++;
    end
    res    = oState;
    iReady = 1'b1;
    tick();
    iReady = 1'b0;
  endtask

  initial begin
    logic [0:127] vec, res, s, held;
    logic [0:127] exp_q[$];
    int lat, sent, got, cyc;
    int first [4];
    bit acc;

    for (int y = 0; y < 256; y++) inv_tab[y] = inv_sbox_math(8'(y));

    rst_n = 1'b0; iValid = 1'b0; iReady = 1'b0; iState = '0;
    sw_valid = 1'b0; sw_ready = 1'b0; sw_state = '0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    check32("rst_ready", 32'(oReady), 1);
    check32("rst_valid", 32'(oValid), 0);
    check32("rst_busy", 32'(oBusy), 0);
    check128("rst_state", oState, '0);

    // Known vector 00..0F with exact latency, and busy right after accept.
    for (int k = 0; k < 16; k++) vec[8*k +: 8] = 8'(k);
    iState = vec; iValid = 1'b1;
    tick();
    iValid = 1'b0;
    iState = rand128();
    check32("busy_after_accept", 32'(oBusy), 1);
    check32("ready_in_run", 32'(oReady), 0);
    lat = 0;
    while (!oValid && lat < 40) begin
      tick();
      lat++;
    end
    check32("known_latency", lat, 4);
    check128("known_spec", oState, 128'h52096ad53036a538bf40a39e81f3d7fb);
    check128("known_model", oState, ref_sub(vec));
    check32("busy_in_done", 32'(oBusy), 0);
    iReady = 1'b1;
    tick();
    iReady = 1'b0;
    check32("release_valid", 32'(oValid), 0);
    check32("release_ready", 32'(oReady), 1);

    // Round-trip corner bytes.
    run_one({16{8'h63}}, res, lat);
    check128("all63", res, '0);
    run_one('0, res, lat);
    check128("all00", res, {16{8'h52}});
    s = rand128();
    s[0:7] = 8'h16;
    s[120:127] = 8'hff;
    run_one(s, res, lat);
    check32("byte0_16", 32'(res[0:7]), 32'h0000_00ff);
    check32("byte15_ff", 32'(res[120:127]), 32'h0000_007d);
    check128("edge_model", res, ref_sub(s));

    // Backpressure: result held for 10 cycles while a new request is ignored.
    s = rand128();
    iState = s; iValid = 1'b1;
    tick();
    iValid = 1'b0;
    lat = 0;
    while (!oValid && lat < 40) begin
      tick();
      lat++;
    end
    held = oState;
    check128("bp_result", held, ref_sub(s));
    iValid = 1'b1;
    iState = rand128();
    for (int i = 0; i < 10; i++) begin
      tick();
      check32("bp_valid", 32'(oValid), 1);
      check32("bp_ready", 32'(oReady), 0);
      check128("bp_state", oState, held);
    end
    iValid = 1'b0;
    iReady = 1'b1;
    tick();
    iReady = 1'b0;
    check32("bp_release", 32'(oValid), 0);
    check32("bp_idle", 32'(oReady), 1);

    // Asynchronous reset two cycles into RUN, then a fresh transaction.
    iState = rand128(); iValid = 1'b1;
    tick();
    iValid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check32("mid_rst_valid", 32'(oValid), 0);
    check32("mid_rst_ready", 32'(oReady), 1);
    check32("mid_rst_busy", 32'(oBusy), 0);
    check128("mid_rst_state", oState, '0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    s = rand128();
    run_one(s, res, lat);
    check32("post_rst_latency", lat, 4);
    check128("post_rst_result", res, ref_sub(s));

    // LANES sweep on the extra instances, all accepting the same vector on the same edge.
    for (int g = 0; g < 4; g++) check32("sw_idle", 32'(sw_oready[g]), 1);
    sw_state = vec; sw_valid = 1'b1;
    tick();
    sw_valid = 1'b0;
    for (int g = 0; g < 4; g++) first[g] = -1;
    for (int c = 1; c <= 20; c++) begin
      tick();
      for (int g = 0; g < 4; g++) begin
        if (sw_ovalid[g] && first[g] < 0) first[g] = c;
      end
    end
    for (int g = 0; g < 4; g++) begin
      check32("sw_latency", first[g], 32'(16 / ((g < 2) ? (1 << g) : (1 << (g + 1)))));
      check128("sw_state", sw_ostate[g], ref_sub(vec));
    end
    sw_ready = 1'b1;
    tick();
    sw_ready = 1'b0;
    for (int g = 0; g < 4; g++) check32("sw_release", 32'(sw_ovalid[g]), 0);

    // Random stream with random iValid/iReady, scored in order.
    sent = 0; got = 0; cyc = 0;
    iValid = 1'b0; iReady = 1'b0;
    while (got < 1000 && cyc < 60000) begin
      if (!iValid && sent < 1000 && $urandom_range(0, 2) != 0) begin
        iValid = 1'b1;
        iState = rand128();
      end
      iReady = ($urandom_range(0, 3) != 0);
      if (oValid && iReady) begin
        check32("stream_pending", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) check128("stream_data", oState, exp_q.pop_front());
        got++;
      end
      acc = iValid && oReady;
      if (acc) begin
        exp_q.push_back(ref_sub(iState));
        sent++;
      end
      tick();
      if (acc) iValid = 1'b0;
      cyc++;
    end
    iValid = 1'b0;
    iReady = 1'b0;
    check32("stream_count", got, 1000);
    check32("stream_left", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
